// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction width, main-control opcodes and the fetch FSM states.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DROP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, valid/ready hand-off to decode, beq redirect.
// Optional stall counter enabled by the FETCH_STALL_CNT_EN macro.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [5:0]         if_opfield,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [2:0]         state_dbg
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    // Handshakes: imem request transfers when imem_req_valid & imem_req_ready on a rising edge;
    // imem responses are single-cycle imem_rsp_valid pulses; decode takes if_instr when
    // if_valid & if_ready. Request valid/address and if_* payload stay stable while waiting.

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_target;

    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign imem_req_addr   = pc;
    assign if_opfield      = if_instr[31:26];
    assign if_pc_plus4     = if_pc + ADDR_W'(4);
    assign state_dbg       = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
            if_instr       <= '0;
            if_pc          <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        state          <= redirect_valid ? S_DROP : S_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (redirect_valid) begin
                            // Wrong-path data arriving with the redirect is simply discarded.
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            if_instr <= imem_rsp_data;
                            if_pc    <= pc;
                            pc       <= pc + ADDR_W'(4);
                            if_valid <= 1'b1;
                            state    <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        state <= S_DROP;
                    end
                end
                S_OUT: begin
                    if (redirect_valid || if_ready) begin
                        if_valid       <= 1'b0;
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    imem_req_valid <= 1'b0;
                    if_valid       <= 1'b0;
                end
            endcase
            // Redirect wins over the pc+4 update; the S_WAIT capture path never runs with it.
            if (redirect_valid && state != S_IDLE) begin
                pc <= redirect_target;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic stalled;

    assign stalled = (state == S_REQ && !imem_req_ready) || state == S_WAIT ||
                     state == S_DROP || (if_valid && !if_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stalled && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: transaction-level fetch model plus imem responder; directed then random steps.
module tb_mips_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [5:0]  if_opfield;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  state_dbg;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_opfield(if_opfield),
        .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .state_dbg(state_dbg)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    // Fetch model: what the next request address must be, whether a request is in flight,
    // whether that request is still on the right path, and which instruction decode should see.
    bit          known = 0;
    bit          idle = 0;
    bit          outstanding = 0;
    bit          live = 0;
    bit          held = 0;
    logic [31:0] exp_next = RESET_PC;
    logic [31:0] cur_addr = '0;
    logic [31:0] held_pc = '0;
    logic [31:0] stall_exp = '0;

    // Memory responder and request log.
    int          rsp_cnt = -1;
    logic [31:0] rsp_addr = '0;
    int          rsp_delay = 0;
    bit          stray_en = 0;
    int          hs_cnt = 0;
    logic [31:0] last_hs_addr = '0;
    logic [31:0] hs_log[$];
    logic [31:0] exp_q[$];
    logic [5:0]  seen_op4 = 6'bxxxxxx;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h4) return 32'h8C01_0004;
        return (addr * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rdy, input bit ifr, input bit redir,
                         input logic [31:0] tgt, input bit do_rst);
        bit          fire;
        bit          exp_req;
        bit          hs;
        bit          deliver;
        logic [31:0] w;
        if (do_rst || !known || idle) redir = 0;
        if (do_rst) rdy = 0;
        fire = 0;
        if (rsp_cnt == 0) begin
            fire = 1;
            rsp_cnt = -1;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
        end
        rst_n          = !do_rst;
        imem_req_ready = rdy;
        if_ready       = ifr;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rsp_valid = fire;
        imem_rsp_data  = fire ? mem_word(rsp_addr) : $urandom;
        if (!fire && stray_en && !outstanding && $urandom_range(0, 7) == 0) imem_rsp_valid = 1;
        exp_req = known && !outstanding && !held && !idle;
        #1;
        if (known) begin
            chk("if_valid", {31'b0, if_valid}, {31'b0, held});
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (exp_req) chk("req_addr", imem_req_addr, exp_next);
            if (held) begin
                w = mem_word(held_pc);
                chk("if_instr", if_instr, w);
                chk("if_pc", if_pc, held_pc);
                chk("if_opfield", {26'b0, if_opfield}, {26'b0, w[31:26]});
                chk("if_pc_plus4", if_pc_plus4, held_pc + 32'd4);
                if (held_pc == 32'h4) seen_op4 = if_opfield;
            end
`ifdef FETCH_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_exp);
`endif
        end
        hs = exp_req && rdy;
        deliver = held && ifr && !redir;
        if (do_rst) begin
            known = 1; idle = 1; outstanding = 0; live = 0; held = 0;
            exp_next = RESET_PC; stall_exp = '0;
        end else if (known) begin
            if ((exp_req && !rdy) || outstanding || (held && !ifr)) stall_exp++;
            if (fire && outstanding) begin
                outstanding = 0;
                if (live && !redir) begin
                    held = 1;
                    held_pc = cur_addr;
                end
            end
            if (deliver) held = 0;
            if (hs) begin
                outstanding = 1; live = 1;
                cur_addr = exp_next; rsp_addr = exp_next;
                rsp_cnt = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(0, 2));
                exp_next = exp_next + 32'd4;
                hs_cnt++; last_hs_addr = cur_addr; hs_log.push_back(cur_addr);
            end
            if (redir) begin
                exp_next = tgt & ~32'h3;
                live = 0;
                held = 0;
            end
            idle = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_hs();
        int n = hs_cnt;
        for (int i = 0; i < 40 && hs_cnt == n; i++) cycle(1, 1, 0, '0, 0);
        chk("hs_seen", hs_cnt - n, 1);
    endtask

    task automatic run_until_held();
        for (int i = 0; i < 40 && !held; i++) cycle(1, 0, 0, '0, 0);
        chk("held_seen", {31'b0, held}, 32'd1);
    endtask

    task automatic run_until_outstanding();
        for (int i = 0; i < 40 && !outstanding; i++) cycle(1, 1, 0, '0, 0);
        chk("outstanding_seen", {31'b0, outstanding}, 32'd1);
    endtask

    initial begin
        logic [31:0] saved_pc;
        logic [31:0] base;
        @(negedge clk);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 1);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, RESET_PC);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);

        // Straight-line fetch with immediate responses.
        rsp_delay = 0;
        repeat (3) run_until_hs();
        exp_q = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) chk("first_addrs", hs_log[i], exp_q.pop_front());
        chk("opfield_lw", {26'b0, seen_op4}, {26'b0, OP_LW});

        // Decode back-pressure for three cycles in S_OUT.
        run_until_held();
        saved_pc = held_pc;
        repeat (3) cycle(1, 0, 0, '0, 0);
        run_until_hs();
        chk("after_stall_addr", last_hs_addr, saved_pc + 32'd4);

        // Redirect while waiting for a slow response.
        rsp_delay = 2;
        run_until_outstanding();
        cycle(1, 1, 1, 32'h40, 0);
        run_until_hs();
        chk("redir_wait_addr", last_hs_addr, 32'h40);

        // Redirect with decode accepting in the same cycle, misaligned target.
        rsp_delay = 0;
        run_until_held();
        cycle(1, 1, 1, 32'h43, 0);
        chk("redir_out_drop", {31'b0, if_valid}, 32'd0);
        run_until_hs();
        chk("redir_out_addr", last_hs_addr, 32'h40);

        // Reset in S_WAIT with the response landing during S_IDLE.
        rsp_delay = 1;
        run_until_outstanding();
        cycle(0, 0, 0, '0, 1);
        chk("rst2_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst2_if_instr", if_instr, 32'h0);
        run_until_hs();
        chk("rst2_addr", last_hs_addr, RESET_PC);

        // PC wrap at the top of the address space.
        rsp_delay = -1;
        cycle(1, 1, 1, 32'hFFFF_FFFE, 0);
        run_until_hs();
        chk("wrap_top_addr", last_hs_addr, 32'hFFFF_FFFC);
        run_until_hs();
        chk("wrap_zero_addr", last_hs_addr, 32'h0);

        // Memory back-pressure for five cycles, then a two-cycle wait.
        rsp_delay = 1;
        for (int i = 0; i < 40 && !(!outstanding && !held && !idle); i++) cycle(0, 1, 0, '0, 0);
        base = stall_exp;
        repeat (5) cycle(0, 1, 0, '0, 0);
        run_until_hs();
        for (int i = 0; i < 40 && outstanding; i++) cycle(1, 1, 0, '0, 0);
        chk("stall_delta_model", stall_exp - base, 32'd7);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_delta", stall_cnt - base, 32'd7);
`endif

        // Random traffic with redirects and stray responses.
        rsp_delay = -1;
        stray_en = 1;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 11) == 0, $urandom, 0);
        end
        stray_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
